// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader: FSM state encoding
// and the word/frame geometry of the load stream.
package loader_pkg;

   localparam int WORD_BYTES = 4;
   localparam int MAX_WORDS  = 64;
   localparam int INSTR_W    = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN   = 3'd1,
      ST_DATA  = 3'd2,
      ST_WRITE = 3'd3,
      ST_CSUM  = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERR   = 3'd6
   } state_t;

endpackage

// File: rtl/instr_word_assembler.sv
// Packs little-endian stream bytes into a 32-bit instruction word; byte k of
// the word lands in bits [8k+7:8k].
module instr_word_assembler
   import loader_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clear_i,
   input  logic               shift_i,
   input  logic [7:0]         byte_i,
   output logic [INSTR_W-1:0] word_o,
   output logic               word_full_o,
   output logic               last_byte_o
);

   logic [INSTR_W-1:0] word_q, word_d;
   logic [1:0]         cnt_q, cnt_d;
   logic               full_q, full_d;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      full_d = full_q;
      if (clear_i) begin
         word_d = '0;
         cnt_d  = '0;
         full_d = 1'b0;
      end else if (shift_i) begin
         word_d[{cnt_q, 3'b000} +: 8] = byte_i;
         cnt_d  = cnt_q + 2'd1;
         full_d = (cnt_q == 2'd3);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         word_q <= '0;
         cnt_q  <= '0;
         full_q <= 1'b0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
         full_q <= full_d;
      end
   end

   assign word_o      = word_q;
   assign word_full_o = full_q;
   assign last_byte_o = (cnt_q == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Receives a framed byte stream (length, instruction bytes, XOR checksum) and
// writes assembled words into instruction RAM while holding the core off.
module instruction_loader #(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                MAX_WORDS = loader_pkg::MAX_WORDS
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [7:0]        byte_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [31:0]       wdata_o,
   output logic              hold_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [6:0]        words_o
);

   import loader_pkg::*;

   state_t              state_q, state_d;
   logic [7:0]          len_q, len_d;
   logic [6:0]          words_q, words_d;
   logic [7:0]          csum_q, csum_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [INSTR_W-1:0]  wdata_q, wdata_d;

   logic                asm_clear, asm_shift;
   logic [INSTR_W-1:0]  asm_word;
   logic                asm_full, asm_last;
   logic                xfer;
   logic [ADDR_W-1:0]   waddr_calc;

   instr_word_assembler u_asm (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clear_i     (asm_clear),
      .shift_i     (asm_shift),
      .byte_i      (byte_i),
      .word_o      (asm_word),
      .word_full_o (asm_full),
      .last_byte_o (asm_last)
   );

   assign byte_ready_o = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
   assign xfer         = byte_valid_i && byte_ready_o;
   assign waddr_calc   = BASE_ADDR + ADDR_W'({words_q, 2'b00});

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      words_d   = words_q;
      csum_d    = csum_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      asm_clear = 1'b0;
      asm_shift = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start_i) begin
               state_d   = ST_LEN;
               len_d     = '0;
               words_d   = '0;
               csum_d    = '0;
               asm_clear = 1'b1;
            end
         end
         ST_LEN: begin
            if (xfer) begin
               len_d = byte_i;
               if (int'(byte_i) > MAX_WORDS)
                  state_d = ST_ERR;
               else if (byte_i == 8'd0)
                  state_d = ST_CSUM;
               else
                  state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (xfer) begin
               asm_shift = 1'b1;
               csum_d    = csum_q ^ byte_i;
               if (asm_last)
                  state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // Latch what is presented this cycle so the write port holds it afterwards.
            asm_clear = 1'b1;
            words_d   = words_q + 7'd1;
            waddr_d   = waddr_calc;
            wdata_d   = asm_word;
            state_d   = (({1'b0, words_q} + 8'd1) == len_q) ? ST_CSUM : ST_DATA;
         end
         ST_CSUM: begin
            if (xfer)
               state_d = (byte_i == csum_q) ? ST_DONE : ST_ERR;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         words_q <= '0;
         csum_q  <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         words_q <= words_d;
         csum_q  <= csum_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign we_o    = (state_q == ST_WRITE) && asm_full;
   assign waddr_o = (state_q == ST_WRITE) ? waddr_calc : waddr_q;
   assign wdata_o = (state_q == ST_WRITE) ? asm_word : wdata_q;
   assign busy_o  = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                    (state_q == ST_WRITE) || (state_q == ST_CSUM);
   assign hold_o  = busy_o || (state_q == ST_ERR);
   assign done_o  = (state_q == ST_DONE);
   assign err_o   = (state_q == ST_ERR);
   assign words_o = words_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: directed frames plus randomized
// sessions, with writes checked by a monitor against a frame-level model.
module tb_instruction_loader;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [7:0]  byte_i;
   logic        byte_valid_i;
   logic        byte_ready_o;
   logic        we_o;
   logic [7:0]  waddr_o;
   logic [31:0] wdata_o;
   logic        hold_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [6:0]  words_o;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t        sb[$];
   logic [7:0] stream[$];
   int         tests    = 0;
   int         failures = 0;
   int         max_gap  = 0;

   instruction_loader #(
      .ADDR_W    (8),
      .BASE_ADDR (8'h00),
      .MAX_WORDS (64)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .byte_i       (byte_i),
      .byte_valid_i (byte_valid_i),
      .byte_ready_o (byte_ready_o),
      .we_o         (we_o),
      .waddr_o      (waddr_o),
      .wdata_o      (wdata_o),
      .hold_o       (hold_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .words_o      (words_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every write the DUT issues must match the oldest expected write.
   always @(negedge clk_i) begin
      if (we_o === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL unexpected_we: got addr 0x%0h data 0x%0h expected no write", waddr_o, wdata_o);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("waddr", 32'(waddr_o), 32'(e.addr));
            check("wdata", wdata_o, e.data);
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got no finish expected finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic pulse_start();
      @(negedge clk_i);
      start_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk_i);
      rst_i        = 1'b1;
      byte_valid_i = 1'b0;
      start_i      = 1'b0;
      repeat (cycles) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   // Offers one byte after a random idle gap; returns at the negedge after acceptance.
   task automatic send_byte(input logic [7:0] b, input bit word_end);
      int n;
      repeat ($urandom_range(max_gap, 0)) @(negedge clk_i);
      byte_i       = b;
      byte_valid_i = 1'b1;
      n = 0;
      while (byte_ready_o !== 1'b1 && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 50) begin
         check("ready_timeout", 32'(byte_ready_o), 32'd1);
      end else begin
         @(posedge clk_i);
         @(negedge clk_i);
         if (word_end) check("we_latency", 32'(we_o), 32'd1);
      end
      byte_valid_i = 1'b0;
   endtask

   task automatic check_output(input bit exp_done, input bit exp_err, input int exp_words);
      check("done", 32'(done_o), 32'(exp_done));
      check("err", 32'(err_o), 32'(exp_err));
      check("hold", 32'(hold_o), 32'(!exp_done));
      check("busy", 32'(busy_o), 32'd0);
      check("ready_idle", 32'(byte_ready_o), 32'd0);
      check("words", 32'(words_o), 32'(exp_words));
      check("sb_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset_outputs();
      check("rst_we", 32'(we_o), 32'd0);
      check("rst_waddr", 32'(waddr_o), 32'd0);
      check("rst_wdata", wdata_o, 32'd0);
      check("rst_hold", 32'(hold_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_words", 32'(words_o), 32'd0);
      check("rst_ready", 32'(byte_ready_o), 32'd0);
   endtask

   // Frame-level model: derive writes and final status from the stream, then drive it.
   task automatic apply_stimulus();
      int         len;
      logic [7:0] x;
      bit         good;
      len = int'(stream[0]);
      x   = 8'h00;
      if (len <= 64) begin
         for (int k = 0; k < len; k++) begin
            wr_t w;
            w.addr = 8'(4 * k);
            w.data = {stream[4*k+4], stream[4*k+3], stream[4*k+2], stream[4*k+1]};
            for (int j = 1; j <= 4; j++) x ^= stream[4*k+j];
            sb.push_back(w);
         end
      end
      pulse_start();
      check("start_busy", 32'(busy_o), 32'd1);
      check("start_hold", 32'(hold_o), 32'd1);
      check("start_flags", {30'd0, done_o, err_o}, 32'd0);
      check("start_words", 32'(words_o), 32'd0);
      if (len > 64) begin
         send_byte(stream[0], 1'b0);
         check("len_err_we", 32'(we_o), 32'd0);
         check_output(1'b0, 1'b1, 0);
      end else begin
         for (int i = 0; i < stream.size(); i++)
            send_byte(stream[i], (i > 0) && (i <= 4 * len) && (i % 4 == 0));
         good = (stream[1 + 4 * len] == x);
         check_output(good, !good, len);
      end
   endtask

   task automatic load_stream(input logic [7:0] a[]);
      stream.delete();
      foreach (a[i]) stream.push_back(a[i]);
   endtask

   initial begin
      logic [7:0] base_frame[];
      rst_i        = 1'b1;
      start_i      = 1'b0;
      byte_i       = 8'h00;
      byte_valid_i = 1'b0;
      do_reset(3);
      check_reset_outputs();

      base_frame = '{8'h02, 8'h93, 8'h80, 8'h10, 8'h00, 8'hB3, 8'h80, 8'h10, 8'h00, 8'h20};
      load_stream(base_frame);
      apply_stimulus();

      base_frame[9] = 8'h21;
      load_stream(base_frame);
      apply_stimulus();

      load_stream('{8'h41});
      apply_stimulus();

      load_stream('{8'h00, 8'h00});
      apply_stimulus();
      pulse_start();
      check("restart_done", 32'(done_o), 32'd0);
      check("restart_busy", 32'(busy_o), 32'd1);
      check("restart_ready", 32'(byte_ready_o), 32'd1);
      do_reset(1);

      // Random frames with stalls, occasional bad length or checksum.
      max_gap = 3;
      for (int s = 0; s < 20; s++) begin
         int  len;
         logic [7:0] x;
         len = ($urandom_range(7, 0) == 0) ? int'($urandom_range(255, 65)) : int'($urandom_range(6, 0));
         stream.delete();
         stream.push_back(8'(len));
         x = 8'h00;
         if (len <= 64) begin
            for (int i = 0; i < 4 * len; i++) begin
               logic [7:0] b;
               b = 8'($urandom);
               x ^= b;
               stream.push_back(b);
            end
            stream.push_back(($urandom_range(3, 0) == 0) ? (x ^ 8'($urandom_range(255, 1))) : x);
         end
         apply_stimulus();
      end

      // Abort mid-session: one word written, then reset drops everything.
      do_reset(1);
      pulse_start();
      sb.push_back('{8'h00, 32'h44332211});
      send_byte(8'h02, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b1);
      send_byte(8'h55, 1'b0);
      do_reset(1);
      check_reset_outputs();
      check("abort_sb_empty", 32'(sb.size()), 32'd0);
      byte_i       = 8'hAA;
      byte_valid_i = 1'b1;
      repeat (4) begin
         @(negedge clk_i);
         check("abort_ready", 32'(byte_ready_o), 32'd0);
      end
      byte_valid_i = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
